// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiply datapath: default dimensions and drain FSM states.
package matrix_pkg;

    localparam int BATCH_SIZE          = 8;
    localparam int LOG_BATCH_SIZE      = 3;
    localparam int OUTPUT_FEATURES     = 8;
    localparam int LOG_OUTPUT_FEATURES = 3;
    localparam int OUTPUT_WIDTH        = 16;

    typedef enum logic [1:0] {
        StWait,
        StLoad,
        StStream
    } drainState_t;

endpackage

// File: rtl/result_quantize.sv
// Requantizes one accumulator: arithmetic shift right, optional ReLU, signed saturation.
// Defining RESULT_DRAIN_RELU_EN clamps negative shifted values to zero before saturation.
module result_quantize #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4
) (
    input  logic [IN_WIDTH-1:0]  inData,
    output logic [OUT_WIDTH-1:0] outData
);

    localparam logic signed [IN_WIDTH-1:0] MAX_VAL = IN_WIDTH'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [IN_WIDTH-1:0] MIN_VAL = IN_WIDTH'(-(2**(OUT_WIDTH-1)));

    logic signed [IN_WIDTH-1:0] shifted;
    logic signed [IN_WIDTH-1:0] clamped;

    always_comb begin
        shifted = $signed(inData) >>> SHIFT;
`ifdef RESULT_DRAIN_RELU_EN
        clamped = shifted[IN_WIDTH-1] ? '0 : shifted;
`else
        clamped = shifted;
`endif
        if (clamped > MAX_VAL) begin
            outData = MAX_VAL[OUT_WIDTH-1:0];
        end else if (clamped < MIN_VAL) begin
            outData = MIN_VAL[OUT_WIDTH-1:0];
        end else begin
            outData = clamped[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/result_drain.sv
// Buffers rows of C from the multiply engine and streams requantized elements row-major.
// Optional RESULT_DRAIN_RELU_EN enables ReLU in the requantizer.
module result_drain #(
    parameter int BATCH_SIZE          = matrix_pkg::BATCH_SIZE,
    parameter int LOG_BATCH_SIZE      = matrix_pkg::LOG_BATCH_SIZE,
    parameter int OUTPUT_FEATURES     = matrix_pkg::OUTPUT_FEATURES,
    parameter int LOG_OUTPUT_FEATURES = matrix_pkg::LOG_OUTPUT_FEATURES,
    parameter int OUTPUT_WIDTH        = matrix_pkg::OUTPUT_WIDTH,
    parameter int RESULT_WIDTH        = 8,
    parameter int SHIFT               = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] rowData,
    input  logic [LOG_BATCH_SIZE-1:0]               rowAddr,
    input  logic                                    rowWrEn,
    output logic [RESULT_WIDTH-1:0]                 outData,
    output logic                                    outValid,
    input  logic                                    outReady,
    output logic [LOG_BATCH_SIZE-1:0]               outRow,
    output logic [LOG_OUTPUT_FEATURES-1:0]          outCol,
    output logic                                    outLast,
    output logic                                    overflow
);

    import matrix_pkg::*;

    localparam logic [LOG_BATCH_SIZE-1:0]      LAST_ROW = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] mem [BATCH_SIZE];
    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] hold;
    logic [BATCH_SIZE-1:0]                   pending;
    logic [BATCH_SIZE-1:0]                   pendingNext;
    logic [LOG_BATCH_SIZE-1:0]               rdRow;
    logic [LOG_OUTPUT_FEATURES-1:0]          rdCol;
    logic [OUTPUT_WIDTH-1:0]                 element;
    logic                                    overflowSet;
    drainState_t                             state;

    always_ff @(posedge clk) begin
        if (rowWrEn) begin
            mem[rowAddr] <= rowData;
        end
    end

    // A write landing on the row being loaded wins and keeps it pending.
    always_comb begin
        pendingNext = pending;
        if (state == StLoad) begin
            pendingNext[rdRow] = 1'b0;
        end
        if (rowWrEn) begin
            pendingNext[rowAddr] = 1'b1;
        end
    end

    assign overflowSet = rowWrEn && pending[rowAddr] && !(state == StLoad && rowAddr == rdRow);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StWait;
            pending  <= '0;
            hold     <= '0;
            rdRow    <= '0;
            rdCol    <= '0;
            outValid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pending <= pendingNext;
            if (overflowSet) begin
                overflow <= 1'b1;
            end
            case (state)
                StWait: begin
                    // Looking at the incoming write saves a cycle on the first row.
                    if (pendingNext[rdRow]) begin
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    hold     <= mem[rdRow];
                    rdCol    <= '0;
                    outValid <= 1'b1;
                    state    <= StStream;
                end
                StStream: begin
                    if (outReady) begin
                        if (rdCol == LAST_COL) begin
                            rdRow    <= (rdRow == LAST_ROW) ? '0 : rdRow + 1'b1;
                            outValid <= 1'b0;
                            state    <= StWait;
                        end else begin
                            rdCol <= rdCol + 1'b1;
                        end
                    end
                end
                default: state <= StWait;
            endcase
        end
    end

    assign element = hold[rdCol*OUTPUT_WIDTH +: OUTPUT_WIDTH];

    result_quantize #(
        .IN_WIDTH  (OUTPUT_WIDTH),
        .OUT_WIDTH (RESULT_WIDTH),
        .SHIFT     (SHIFT)
    ) quantize (
        .inData  (element),
        .outData (outData)
    );

    assign outRow  = rdRow;
    assign outCol  = rdCol;
    assign outLast = outValid && rdRow == LAST_ROW && rdCol == LAST_COL;

endmodule

// File: doc/result_drain.md
# result_drain

Output-side stage that sits directly downstream of the matrix multiply engine. It accepts the rows of C that the engine writes (one row of OUTPUT_FEATURES wide accumulators per write strobe) into a BATCH_SIZE-row buffer. It requantizes each element to RESULT_WIDTH with an arithmetic shift and saturation, then streams the elements out in row-major order over a valid/ready handshake. The engine has no backpressure, so this block always accepts writes and flags overwrites of undrained rows.

## Interface
- BATCH_SIZE, 8, rows of C per batch (M)
- LOG_BATCH_SIZE, 3, row address width
- OUTPUT_FEATURES, 8, elements per row (O)
- LOG_OUTPUT_FEATURES, 3, column index width
- OUTPUT_WIDTH, 16, signed accumulator width per element
- RESULT_WIDTH, 8, signed streamed element width
- SHIFT, 4, arithmetic right shift applied before saturation

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- rowData  in  OUTPUT_FEATURES*OUTPUT_WIDTH  row of C; element j at bits [j*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- rowAddr  in  LOG_BATCH_SIZE  row index of rowData
- rowWrEn  in  1  write strobe, one row per cycle
- outData  out  RESULT_WIDTH  requantized element
- outValid  out  1  outData valid
- outReady  in  1  consumer accepts
- outRow  out  LOG_BATCH_SIZE  row of current element
- outCol  out  LOG_OUTPUT_FEATURES  column of current element
- outLast  out  1  last element of batch (row BATCH_SIZE-1, col OUTPUT_FEATURES-1)
- overflow  out  1  sticky: an undrained row was overwritten

## Operation
- Storage:
  - row buffer mem[BATCH_SIZE], one pending bit per row, holding register hold, drain pointers rdRow/rdCol, FSM.
  - rowWrEn writes mem[rowAddr] and sets pending[rowAddr].
  - If pending[rowAddr] was already 1, overflow sets; the data is overwritten; overflow clears only on reset.
- FSM:
  - WAIT: if pending[rdRow], go to LOAD.
  - LOAD: hold <= mem[rdRow]; clear pending[rdRow]; rdCol <= 0; go to STREAM.
  - STREAM: outValid=1. On outValid&&outReady:
    - if rdCol==OUTPUT_FEATURES-1: rdRow increments and wraps BATCH_SIZE-1 -> 0, then go to WAIT;
    - otherwise rdCol increments.
- Simultaneous rowWrEn to rdRow during LOAD:
  - the write wins, so pending stays 1 and mem takes the new data;
  - hold captures the old data;
  - overflow is not set, because the row is being drained.
- Conversion of element rdCol of hold:
  - signed arithmetic shift right by SHIFT;
  - saturate to [-2^(RESULT_WIDTH-1), 2^(RESULT_WIDTH-1)-1].
- outRow=rdRow, outCol=rdCol. outLast=outValid && rdRow==BATCH_SIZE-1 && rdCol==OUTPUT_FEATURES-1.
- Reset mid-stream: all state is cleared immediately. Buffered rows are discarded and the drain restarts at row 0.

## Timing
- Reset values: outValid 0, outData 0, outRow 0, outCol 0, outLast 0, overflow 0, pending all 0, hold 0, FSM WAIT.
- Latency: rowWrEn at cycle t with FSM in WAIT on that row, giving pending at t+1, LOAD at t+1, and first outValid at t+2.
- Throughput: OUTPUT_FEATURES beats per row, plus 2 bubble cycles (WAIT, LOAD) between rows.
- Handshake: while outValid && !outReady, outData, outRow, outCol and outLast are held stable. outValid never drops without a handshake, except on reset.
- outData is combinational from registered hold/rdCol, with no extra output register.

## Configuration
- RESULT_DRAIN_RELU_EN:
  - Defined: after the shift, negative values become 0 before saturation, so outData lies in [0, 2^(RESULT_WIDTH-1)-1].
  - Undefined: signed saturation as above.

## Structure
- Shared package matrix_pkg holds:
  - the FSM state typedef (WAIT, LOAD, STREAM);
  - default dimension constants shared with the multiply engine (BATCH_SIZE, OUTPUT_FEATURES, OUTPUT_WIDTH and their logs).
- One sub-module, result_quantize: combinational shift, optional ReLU, saturate, one element wide. It is instantiated once, on the selected element.

## Test plan
- Reset: hold rst low with random inputs -> every output 0; after release, outValid stays 0 until a rowWrEn.
- Single row: rowAddr 0, element j = 16*(j+1), outReady=1 -> outValid at t+2, outData 1..8 on consecutive cycles, outRow 0, outCol 0..7, outLast never set.
- Saturation: elements 0x7FFF, 0x8000, 0xFFF0, 0x0000 -> 127, -128, -1, 0 without the macro; 127, 0, 0, 0 with RESULT_DRAIN_RELU_EN.
- Backpressure: drop outReady for 5 cycles at col 3 -> outData, outCol=3 and outRow stay constant; the stream resumes at col 3 with no beat lost or duplicated.
- Full batch with wrap: rows 0..7 written back-to-back, outReady=1 -> 64 beats in row-major order; outLast only on row 7 col 7; a further write to row 0 drains next.
- Overflow: write row 3 twice (values A then B) while the drain is stalled on row 0 -> overflow=1 and stays 1; row 3 streams B.
